rv_scoreboard_hazard_unit: RTL and testbench
============================================

# rv_scoreboard_hazard_unit

Parametrised register scoreboard and trap-drain sequencer for RISCVBusiness pipelines with multiple writeback ports and multi-cycle functional units. It tracks in-flight register writes per architectural register, stalls issue on RAW/WAW hazards, and sequences trap entry. Trap entry drains all outstanding writes and data-memory traffic, then inserts the privileged PC with a one-cycle pipeline flush. It sits between decode/issue and the writeback stages, generalising the fixed three-stage hazard logic to N in-flight writes.

## Interface
- NREGS, 32: architectural registers; AW = $clog2(NREGS)
- NRS, 2: source operands checked per issue
- NWB, 2: writeback ports
- MAX_INFLIGHT, 3: max outstanding writes per register; CW = $clog2(MAX_INFLIGHT+1)
- WAW_STALL, 1: 1 = stall when the destination already has a pending write
- BYPASS_WB, 1: 1 = a source whose last pending write retires this cycle is not a hazard

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction presented for issue
- issue_rs  in  NRS*AW  source register indices, packed, slot 0 in LSBs
- issue_rs_used  in  NRS  per-source valid
- issue_rd  in  AW  destination index
- issue_rd_write  in  1  instruction writes rd
- wb_valid  in  NWB  per-port writeback retire
- wb_rd  in  NWB*AW  per-port retired destination, packed
- trap_req  in  1  trap/interrupt entry request
- trap_pc  in  32  handler address (xTVEC-derived)
- d_mem_busy  in  1  data memory transaction outstanding
- issue_stall  out  1  issue blocked this cycle
- raw_hazard  out  1  a used source has a pending write
- waw_hazard  out  1  rd has a pending write, or its counter is saturated
- busy_vec  out  NREGS  bit r = count[r] != 0
- drain_active  out  1  FSM in DRAIN
- insert_priv_pc  out  1  redirect fetch to priv_pc
- priv_pc  out  32  latched trap_pc
- pipe_flush  out  1  flush all stages
- wb_underflow  out  1  sticky: writeback to a register with zero count

## Operation
- Per-register counters count[1..NREGS-1] of width CW. Register 0 is never tracked: rd=0 never increments, and rs=0 never hazards.
- raw_hazard: any slot i with issue_rs_used[i], rs_i!=0, and count[rs_i]!=0. If BYPASS_WB=1, a slot is exempt when count[rs_i] equals the number of writeback ports retiring rs_i this cycle.
- waw_hazard: issue_rd_write, rd!=0, and either (WAW_STALL and count[rd]!=0) or count[rd]==MAX_INFLIGHT. Saturation always stalls, whatever the WAW_STALL setting.
- issue_stall = issue_valid & (raw_hazard | waw_hazard | state!=IDLE | trap_req).
- Accepted issue = issue_valid & ~issue_stall.
- Counter update per register: next = count + inc - dec.
  - inc = accepted issue writing this register.
  - dec = number of wb ports retiring it, up to NWB.
  - Simultaneous issue and writeback to the same register nets correctly; no write is lost.
- A decrement that would go below zero clamps to 0 and sets wb_underflow. wb_underflow clears only on RST.
- FSM states:
  - IDLE: trap_req -> DRAIN; latch trap_pc into priv_pc.
  - DRAIN: all counters zero and ~d_mem_busy -> REDIRECT, otherwise hold. Writebacks keep retiring during DRAIN.
  - REDIRECT: insert_priv_pc=1 and pipe_flush=1 for exactly one cycle -> IDLE.
  - trap_req is ignored outside IDLE.

## Timing
- Reset values: all counters 0, state IDLE, priv_pc 0, wb_underflow 0. All outputs 0 at reset: busy_vec, issue_stall, raw_hazard, waw_hazard, drain_active, insert_priv_pc, pipe_flush.
- Hazard and stall outputs are combinational from registered counts plus the current-cycle wb inputs (bypass path only).
- Counter changes become visible in busy_vec the cycle after the accepting edge.
- Trap latency: trap_req in cycle T means DRAIN is at T+1 at the earliest and REDIRECT at T+2 at the earliest.
  - insert_priv_pc is asserted no earlier than T+2.
  - It asserts in the cycle after DRAIN first observes the drained condition.
- RST asserted mid-DRAIN or mid-REDIRECT: immediate return to IDLE, counters cleared, no redirect issued.

## Test plan
- Issue rd=5 (accepted).
  - Next cycle, issue rs1=5 -> raw_hazard=1, issue_stall=1.
  - Writeback wb_rd[0]=5 with BYPASS_WB=1 -> same-cycle raw_hazard=0, issue accepted, busy_vec[5]=0 afterwards.
- WAW_STALL=0, MAX_INFLIGHT=3.
  - Three accepted issues to rd=7 -> count=3; fourth issue to rd=7 -> waw_hazard=1.
  - Writeback on port 0 and port 1 to rd=7 in one cycle -> count=1.
- Issue to rd=0 repeatedly with rs1=0 -> never stalls, busy_vec stays 0.
- Writeback rd=9 while count[9]=0 -> wb_underflow=1 and stays 1; counters unchanged.
- Pending writes on x3 and x4, d_mem_busy=1, trap_req with trap_pc=0x8000_0100.
  - Result: drain_active=1, issue_stall=1.
  - Retire both writes, then drop d_mem_busy -> next cycle one pulse of insert_priv_pc=1, pipe_flush=1, priv_pc=0x8000_0100, then IDLE.
- Assert RST during DRAIN with count[3]=2 -> all outputs 0 and busy_vec=0; no insert_priv_pc after release.

Source files
------------

// File: rtl/rv_scoreboard_hazard_unit.sv
// rv_scoreboard_hazard_unit
// Per-register in-flight write scoreboard with RAW/WAW issue stall and a
// trap-entry sequencer (IDLE -> DRAIN -> REDIRECT -> IDLE).
//
// Issue handshake: issue_valid is the request and ~issue_stall is the ready.
// An instruction is accepted exactly in a cycle where issue_valid=1 and
// issue_stall=0. Stall is combinational from registered counts plus the
// current-cycle writebacks, so the issuer may hold or change its request
// freely while stalled. Writebacks (wb_valid) are unconditional retires.
module rv_scoreboard_hazard_unit #(
  parameter int NREGS        = 32,
  parameter int NRS          = 2,
  parameter int NWB          = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int WAW_STALL    = 1,
  parameter int BYPASS_WB    = 1,
  localparam int AW          = $clog2(NREGS),
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              issue_valid,
  input  logic [NRS*AW-1:0] issue_rs,
  input  logic [NRS-1:0]    issue_rs_used,
  input  logic [AW-1:0]     issue_rd,
  input  logic              issue_rd_write,
  input  logic [NWB-1:0]    wb_valid,
  input  logic [NWB*AW-1:0] wb_rd,
  input  logic              trap_req,
  input  logic [31:0]       trap_pc,
  input  logic              d_mem_busy,
  output logic              issue_stall,
  output logic              raw_hazard,
  output logic              waw_hazard,
  output logic [NREGS-1:0]  busy_vec,
  output logic              drain_active,
  output logic              insert_priv_pc,
  output logic [31:0]       priv_pc,
  output logic              pipe_flush,
  output logic              wb_underflow,
  output logic [1:0]        dbg_state
);

  localparam int DW = $clog2(NWB + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_count      [NREGS];
  logic [CW-1:0]   w_count_next [NREGS];
  logic [DW-1:0]   w_dec        [NREGS];
  logic [31:0]     r_priv_pc;
  logic            r_underflow;
  logic            w_underflow_evt;
  logic            w_accept;
  logic            w_all_zero;
  int              w_sum;

  // Count how many writeback ports retire each register this cycle.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_dec[r] = '0;
      for (int p = 0; p < NWB; p++) begin
        if (wb_valid[p] && (wb_rd[p*AW +: AW] == AW'(r)) && (r != 0)) begin
          w_dec[r] = w_dec[r] + DW'(1);
        end
      end
    end
  end

  // RAW: a used nonzero source with pending writes, unless they all retire now.
  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < NRS; i++) begin
      if (issue_rs_used[i] && (issue_rs[i*AW +: AW] != '0) &&
          (r_count[issue_rs[i*AW +: AW]] != '0)) begin
        if (!((BYPASS_WB != 0) &&
              (int'(r_count[issue_rs[i*AW +: AW]]) == int'(w_dec[issue_rs[i*AW +: AW]])))) begin
          raw_hazard = 1'b1;
        end
      end
    end
  end

  // WAW: pending destination (optional) or saturated counter (always).
  always_comb begin
    waw_hazard = 1'b0;
    if (issue_rd_write && (issue_rd != '0)) begin
      if (((WAW_STALL != 0) && (r_count[issue_rd] != '0)) ||
          (int'(r_count[issue_rd]) == MAX_INFLIGHT)) begin
        waw_hazard = 1'b1;
      end
    end
  end

  assign issue_stall = issue_valid &
                       (raw_hazard | waw_hazard | (r_state != ST_IDLE) | trap_req);
  assign w_accept    = issue_valid & ~issue_stall;

  // Next counter values: count + inc - dec, clamped at zero on underflow.
  always_comb begin
    w_underflow_evt = 1'b0;
    w_sum           = 0;
    for (int r = 0; r < NREGS; r++) begin
      w_count_next[r] = '0;
      if (r != 0) begin
        w_sum = int'(r_count[r]) - int'(w_dec[r]);
        if (w_accept && issue_rd_write && (issue_rd == AW'(r))) begin
          w_sum = w_sum + 1;
        end
        if (w_sum < 0) begin
          w_underflow_evt = 1'b1;
        end else begin
          w_count_next[r] = CW'(w_sum);
        end
      end
    end
  end

  // Busy vector and drained condition from registered counts.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy_vec[r] = (r_count[r] != '0);
    end
  end

  assign w_all_zero = (busy_vec == '0);

  // Trap sequencer next-state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (trap_req) w_state_next = ST_DRAIN;
      ST_DRAIN:    if (w_all_zero && !d_mem_busy) w_state_next = ST_REDIRECT;
      ST_REDIRECT: w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // State, counters, latched handler PC and sticky underflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_count     <= '{default: '0};
      r_priv_pc   <= 32'h0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_underflow <= r_underflow | w_underflow_evt;
      if ((r_state == ST_IDLE) && trap_req) begin
        r_priv_pc <= trap_pc;
      end
    end
  end

  assign drain_active   = (r_state == ST_DRAIN);
  assign insert_priv_pc = (r_state == ST_REDIRECT);
  assign pipe_flush     = (r_state == ST_REDIRECT);
  assign priv_pc        = r_priv_pc;
  assign wb_underflow   = r_underflow;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_rv_scoreboard_hazard_unit.sv
// Directed bench for rv_scoreboard_hazard_unit. Main instance uses
// WAW_STALL=0; a second instance with WAW_STALL=1 shares all inputs.
module tb_rv_scoreboard_hazard_unit;

  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          issue_valid;
  logic [2*AW-1:0] issue_rs;
  logic [1:0]    issue_rs_used;
  logic [AW-1:0] issue_rd;
  logic          issue_rd_write;
  logic [1:0]    wb_valid;
  logic [2*AW-1:0] wb_rd;
  logic          trap_req;
  logic [31:0]   trap_pc;
  logic          d_mem_busy;

  logic          issue_stall, raw_hazard, waw_hazard, drain_active;
  logic          insert_priv_pc, pipe_flush, wb_underflow;
  logic [31:0]   busy_vec, priv_pc;
  logic [1:0]    dbg_state;

  logic          s_issue_stall, s_raw_hazard, s_waw_hazard, s_drain_active;
  logic          s_insert_priv_pc, s_pipe_flush, s_wb_underflow;
  logic [31:0]   s_busy_vec, s_priv_pc;
  logic [1:0]    s_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  rv_scoreboard_hazard_unit #(.WAW_STALL(0)) u_dut (
    .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_rs(issue_rs),
    .issue_rs_used(issue_rs_used), .issue_rd(issue_rd), .issue_rd_write(issue_rd_write),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .trap_req(trap_req), .trap_pc(trap_pc),
    .d_mem_busy(d_mem_busy), .issue_stall(issue_stall), .raw_hazard(raw_hazard),
    .waw_hazard(waw_hazard), .busy_vec(busy_vec), .drain_active(drain_active),
    .insert_priv_pc(insert_priv_pc), .priv_pc(priv_pc), .pipe_flush(pipe_flush),
    .wb_underflow(wb_underflow), .dbg_state(dbg_state)
  );

  rv_scoreboard_hazard_unit #(.WAW_STALL(1)) u_dut_ws (
    .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_rs(issue_rs),
    .issue_rs_used(issue_rs_used), .issue_rd(issue_rd), .issue_rd_write(issue_rd_write),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .trap_req(trap_req), .trap_pc(trap_pc),
    .d_mem_busy(d_mem_busy), .issue_stall(s_issue_stall), .raw_hazard(s_raw_hazard),
    .waw_hazard(s_waw_hazard), .busy_vec(s_busy_vec), .drain_active(s_drain_active),
    .insert_priv_pc(s_insert_priv_pc), .priv_pc(s_priv_pc), .pipe_flush(s_pipe_flush),
    .wb_underflow(s_wb_underflow), .dbg_state(s_dbg_state)
  );

  // Clock and reset block.
  always #5 CLK = ~CLK;

  // Driver tasks. Inputs change 1ns after a rising edge; checks happen 3ns after.
  task automatic idle_inputs();
    issue_valid = 0; issue_rs = '0; issue_rs_used = '0; issue_rd = '0;
    issue_rd_write = 0; wb_valid = '0; wb_rd = '0; trap_req = 0;
    trap_pc = '0; d_mem_busy = 0;
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    cyc(); RST = 1; idle_inputs(); cyc(); cyc(); RST = 0;
  endtask

  task automatic drive_issue(input logic [AW-1:0] rd, input logic wr,
                             input logic [AW-1:0] rs0, input logic used0);
    issue_valid = 1; issue_rd = rd; issue_rd_write = wr;
    issue_rs = {5'd0, rs0}; issue_rs_used = {1'b0, used0};
  endtask

  task automatic test_reset();
    RST = 1; idle_inputs();
    cyc(); cyc(); settle();
    n_tests++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h exp 0", busy_vec); end
    n_tests++; if ({issue_stall, raw_hazard, waw_hazard, drain_active, insert_priv_pc, pipe_flush, wb_underflow} !== 7'b0)
      begin n_fail++; $display("FAIL reset_flags: got %b exp 0", {issue_stall, raw_hazard, waw_hazard, drain_active, insert_priv_pc, pipe_flush, wb_underflow}); end
    n_tests++; if (priv_pc !== 32'h0) begin n_fail++; $display("FAIL reset_priv_pc: got %h exp 0", priv_pc); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    cyc(); RST = 0;
  endtask

  task automatic test_raw_bypass();
    do_reset();
    drive_issue(5'd5, 1, 5'd0, 0); settle();
    n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue_stall: got %b exp 0", issue_stall); end
    cyc();
    drive_issue(5'd5, 1, 5'd5, 1); settle();
    n_tests++; if (busy_vec[5] !== 1'b1) begin n_fail++; $display("FAIL raw_busy5: got %b exp 1", busy_vec[5]); end
    n_tests++; if ({raw_hazard, issue_stall} !== 2'b11) begin n_fail++; $display("FAIL raw_hazard_stall: got %b exp 11", {raw_hazard, issue_stall}); end
    n_tests++; if (waw_hazard !== 1'b0) begin n_fail++; $display("FAIL waw_nostall_cfg: got %b exp 0", waw_hazard); end
    n_tests++; if (s_waw_hazard !== 1'b1) begin n_fail++; $display("FAIL waw_stall_cfg: got %b exp 1", s_waw_hazard); end
    cyc();
    drive_issue(5'd0, 0, 5'd5, 1); wb_valid = 2'b01; wb_rd = {5'd0, 5'd5}; settle();
    n_tests++; if ({raw_hazard, issue_stall} !== 2'b00) begin n_fail++; $display("FAIL raw_bypass: got %b exp 00", {raw_hazard, issue_stall}); end
    cyc(); idle_inputs(); settle();
    n_tests++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL raw_busy_after_wb: got %h exp 0", busy_vec); end
  endtask

  task automatic test_waw_saturate();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_issue(5'd7, 1, 5'd0, 0); settle();
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL waw_issue%0d_stall: got %b exp 0", k, issue_stall); end
      cyc();
    end
    drive_issue(5'd7, 1, 5'd0, 0); settle();
    n_tests++; if ({waw_hazard, issue_stall} !== 2'b11) begin n_fail++; $display("FAIL waw_saturated: got %b exp 11", {waw_hazard, issue_stall}); end
    cyc();
    idle_inputs(); wb_valid = 2'b11; wb_rd = {5'd7, 5'd7};
    cyc(); idle_inputs(); settle();
    n_tests++; if (busy_vec !== 32'h0000_0080) begin n_fail++; $display("FAIL waw_after_dual_wb: got %h exp 00000080", busy_vec); end
    // count[7]=1: simultaneous issue and retire keeps it at 1
    drive_issue(5'd7, 1, 5'd0, 0); wb_valid = 2'b01; wb_rd = {5'd0, 5'd7}; settle();
    n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL waw_net_issue_stall: got %b exp 0", issue_stall); end
    cyc(); idle_inputs(); settle();
    n_tests++; if (busy_vec !== 32'h0000_0080) begin n_fail++; $display("FAIL waw_net_busy: got %h exp 00000080", busy_vec); end
    wb_valid = 2'b10; wb_rd = {5'd7, 5'd0};
    cyc(); idle_inputs(); settle();
    n_tests++; if ({busy_vec, wb_underflow} !== 33'h0) begin n_fail++; $display("FAIL waw_final_drain: got busy %h uf %b exp 0 0", busy_vec, wb_underflow); end
  endtask

  task automatic test_x0();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_issue(5'd0, 1, 5'd0, 1); settle();
      n_tests++; if (issue_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall%0d: got %b exp 0", k, issue_stall); end
      cyc();
    end
    idle_inputs(); settle();
    n_tests++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL x0_busy: got %h exp 0", busy_vec); end
  endtask

  task automatic test_underflow();
    do_reset();
    wb_valid = 2'b10; wb_rd = {5'd9, 5'd0};
    cyc(); idle_inputs(); settle();
    n_tests++; if (wb_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b exp 1", wb_underflow); end
    n_tests++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL uf_counters: got %h exp 0", busy_vec); end
    cyc(); cyc(); settle();
    n_tests++; if (wb_underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b exp 1", wb_underflow); end
  endtask

  task automatic test_trap();
    do_reset();
    drive_issue(5'd3, 1, 5'd0, 0); cyc();
    drive_issue(5'd4, 1, 5'd0, 0); cyc();
    drive_issue(5'd10, 1, 5'd0, 0); d_mem_busy = 1; trap_req = 1; trap_pc = 32'h8000_0100; settle();
    n_tests++; if (issue_stall !== 1'b1) begin n_fail++; $display("FAIL trap_req_stall: got %b exp 1", issue_stall); end
    cyc(); trap_req = 0; trap_pc = 32'h0; settle();
    n_tests++; if ({drain_active, issue_stall} !== 2'b11) begin n_fail++; $display("FAIL trap_drain: got %b exp 11", {drain_active, issue_stall}); end
    n_tests++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL trap_state_drain: got %0d exp 1", dbg_state); end
    n_tests++; if (busy_vec !== 32'h0000_0018) begin n_fail++; $display("FAIL trap_pending: got %h exp 00000018", busy_vec); end
    wb_valid = 2'b11; wb_rd = {5'd4, 5'd3};
    cyc(); wb_valid = '0; wb_rd = '0; settle();
    n_tests++; if ({drain_active, insert_priv_pc, busy_vec} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL trap_hold_mem: got drain %b ins %b busy %h exp 1 0 0", drain_active, insert_priv_pc, busy_vec); end
    d_mem_busy = 0; settle();
    n_tests++; if ({drain_active, insert_priv_pc} !== 2'b10) begin n_fail++; $display("FAIL trap_observe: got %b exp 10", {drain_active, insert_priv_pc}); end
    cyc(); settle();
    n_tests++; if ({insert_priv_pc, pipe_flush, drain_active} !== 3'b110) begin n_fail++; $display("FAIL trap_redirect: got %b exp 110", {insert_priv_pc, pipe_flush, drain_active}); end
    n_tests++; if (priv_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL trap_priv_pc: got %h exp 80000100", priv_pc); end
    cyc(); idle_inputs(); issue_valid = 1; settle();
    n_tests++; if ({insert_priv_pc, pipe_flush, drain_active, issue_stall} !== 4'b0) begin n_fail++; $display("FAIL trap_back_idle: got %b exp 0000", {insert_priv_pc, pipe_flush, drain_active, issue_stall}); end
    idle_inputs();
  endtask

  task automatic test_reset_drain();
    do_reset();
    drive_issue(5'd3, 1, 5'd0, 0); cyc();
    drive_issue(5'd3, 1, 5'd0, 0); cyc();
    idle_inputs(); trap_req = 1; trap_pc = 32'h1234_5678; d_mem_busy = 1;
    cyc(); trap_req = 0; settle();
    n_tests++; if ({drain_active, busy_vec[3]} !== 2'b11) begin n_fail++; $display("FAIL rstd_in_drain: got %b exp 11", {drain_active, busy_vec[3]}); end
    RST = 1; #1;
    n_tests++; if ({busy_vec, issue_stall, raw_hazard, waw_hazard, drain_active, insert_priv_pc, pipe_flush, wb_underflow} !== 39'h0)
      begin n_fail++; $display("FAIL rstd_async_clear: got busy %h drain %b", busy_vec, drain_active); end
    n_tests++; if (priv_pc !== 32'h0) begin n_fail++; $display("FAIL rstd_priv_pc: got %h exp 0", priv_pc); end
    cyc(); d_mem_busy = 0; RST = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(); settle();
      n_tests++; if ({insert_priv_pc, pipe_flush, drain_active} !== 3'b0) begin n_fail++; $display("FAIL rstd_no_redirect%0d: got %b exp 000", k, {insert_priv_pc, pipe_flush, drain_active}); end
    end
  endtask

  initial begin
    test_reset();
    test_raw_bypass();
    test_waw_saturate();
    test_x0();
    test_underflow();
    test_trap();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
